// File: rtl/cfg_chain_pkg.sv
// Shared types and width helpers for the configuration scan-chain loader.
package cfg_chain_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_EMIT,
      S_DONE,
      S_ERR
   } cfg_state_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned idx_width(input int unsigned chain_len, input int unsigned word_w);
      return cnt_width((word_w > 0) ? chain_len / word_w : 1);
   endfunction

   function automatic int unsigned bit_width(input int unsigned word_w);
      return cnt_width(word_w);
   endfunction

endpackage

// File: rtl/cfg_chain_serdes.sv
// Word-wide PISO/SIPO pair: shifts a latched word out LSB first while
// collecting the returning serial bits MSB-in, with a per-word bit counter.
module cfg_chain_serdes
   import cfg_chain_pkg::*;
#(
   parameter int unsigned WORD_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [WORD_W-1:0] par_i,
   input  logic              shift_i,
   input  logic              ser_i,
   output logic              ser_o,
   output logic [WORD_W-1:0] par_o,
   output logic              last_bit_o
);

   localparam int unsigned BW = bit_width(WORD_W);

   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [WORD_W-1:0] rreg_q, rreg_d;
   logic [BW-1:0]     cnt_q, cnt_d;

   always_comb begin
      sreg_d = sreg_q;
      rreg_d = rreg_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         sreg_d = par_i;
         cnt_d  = '0;
      end else if (shift_i) begin
         sreg_d             = sreg_q >> 1;
         rreg_d             = rreg_q >> 1;
         rreg_d[WORD_W-1]   = ser_i;
         cnt_d              = cnt_q + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sreg_q <= '0;
         rreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         rreg_q <= rreg_d;
         cnt_q  <= cnt_d;
      end
   end

   assign ser_o      = sreg_q[0];
   assign par_o      = rreg_q;
   assign last_bit_o = (cnt_q == BW'(WORD_W - 1));

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads the configuration scan chain word by word from a valid/ready stream
// and returns the displaced chain contents as a readback stream.
module cfg_chain_loader
   import cfg_chain_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 128,
   parameter int unsigned WORD_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              s_valid,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              m_valid,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              chain_di,
   output logic              chain_en,
   input  logic              chain_do,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned NW    = (WORD_W > 0) ? CHAIN_LEN / WORD_W : 1;
   localparam int unsigned IDX_W = idx_width(CHAIN_LEN, WORD_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

   generate
      if (WORD_W == 0 || (CHAIN_LEN % WORD_W) != 0) begin : g_bad_params
         $error("cfg_chain_loader: CHAIN_LEN must be a nonzero multiple of WORD_W");
      end
   endgenerate

   cfg_state_t       state_q;
   logic [IDX_W-1:0] idx_q;
   logic             done_q;
   logic             err_q;

   logic             at_last;
   logic             frame_ok;
   logic             word_load;
   logic             ser_out;
   logic             last_bit;
   logic [WORD_W-1:0] rword;

   assign at_last   = (idx_q == LAST_IDX);
   assign frame_ok  = (at_last == s_last);
   assign word_load = (state_q == S_LOAD) && s_valid && frame_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_q <= S_LOAD;
                  idx_q   <= '0;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
               end
            end
            S_LOAD: begin
               if (s_valid) begin
                  // A mis-framed word is consumed but never reaches the chain.
                  if (!frame_ok) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               if (last_bit) state_q <= S_EMIT;
            end
            S_EMIT: begin
               if (m_ready) begin
                  if (at_last) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + IDX_W'(1);
                     state_q <= S_LOAD;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   cfg_chain_serdes #(
      .WORD_W(WORD_W)
   ) u_serdes (
      .clk        (clk),
      .reset      (reset),
      .load_i     (word_load),
      .par_i      (s_data),
      .shift_i    (state_q == S_SHIFT),
      .ser_i      (chain_do),
      .ser_o      (ser_out),
      .par_o      (rword),
      .last_bit_o (last_bit)
   );

   assign chain_en = (state_q == S_SHIFT);
   assign chain_di = chain_en & ser_out;
   assign s_ready  = (state_q == S_LOAD);
   assign m_valid  = (state_q == S_EMIT);
   assign m_data   = rword;
   assign m_last   = m_valid & at_last;
   assign busy     = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_EMIT);
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader with a 16-bit scan chain model behind chain_en.
module tb_cfg_chain_loader;

   localparam int unsigned WW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          s_valid = 1'b0;
   logic [WW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          m_ready = 1'b0;
   logic          s_ready, m_valid, m_last, chain_di, chain_en, chain_do, busy, done, err;
   logic [WW-1:0] m_data;

   logic [15:0]   chain_m = 16'hBEEF;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   // Head enters at the MSB, tail is bit 0.
   always @(posedge clk) if (chain_en) chain_m <= {chain_di, chain_m[15:1]};
   assign chain_do = chain_m[0];

   cfg_chain_loader #(
      .CHAIN_LEN(16),
      .WORD_W   (WW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_last   (m_last),
      .m_ready  (m_ready),
      .chain_di (chain_di),
      .chain_en (chain_en),
      .chain_do (chain_do),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_emit();
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   // Offers one word, then observes the shift burst until readback is valid.
   task automatic xfer_word(input logic [WW-1:0] d, input logic last, input int start_at,
                            output logic [WW-1:0] rd, output logic rl, output int lat,
                            output int en_n, output logic [WW-1:0] di_seq, output bit to);
      int n;
      to = 0; en_n = 0; di_seq = '0;
      s_valid = 1'b1; s_data = d; s_last = last;
      n = 0;
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) to = 1;
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      lat = 1;
      while (!m_valid && lat < 50) begin
         start = (lat == start_at);
         if (chain_en) begin
            if (en_n < WW) di_seq[en_n] = chain_di;
            en_n++;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (!m_valid) to = 1;
      rd = m_data;
      rl = m_last;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({s_ready, m_valid, m_data, m_last, chain_di, chain_en, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {s_ready, m_valid, m_data, m_last, chain_di, chain_en, busy, done, err});
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b s_ready=%b expected 0 0", busy, s_ready);
      end
   endtask

   task automatic test_clean_load();
      logic [WW-1:0] rd, seq; logic rl; int lat, en_n; bit to;
      do_start();
      checks++;
      if (busy !== 1'b1 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL clean_start: busy=%b s_ready=%b expected 1 1", busy, s_ready);
      end
      xfer_word(8'h5A, 1'b0, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL clean_timeout0: got %b expected 0", to); end
      checks++;
      if (lat !== WW + 1) begin errors++; $display("FAIL clean_latency: got %0d expected %0d", lat, WW + 1); end
      checks++;
      if (en_n !== WW) begin errors++; $display("FAIL burst_len: got %0d expected %0d", en_n, WW); end
      checks++;
      if (seq !== 8'h5A) begin errors++; $display("FAIL burst_di_seq: got %b expected %b", seq, 8'h5A); end
      checks++;
      if (rd !== 8'hEF || rl !== 1'b0) begin
         errors++; $display("FAIL clean_rd0: got %h last=%b expected ef last=0", rd, rl);
      end
      finish_emit();
      xfer_word(8'hC3, 1'b1, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || rd !== 8'hBE || rl !== 1'b1) begin
         errors++; $display("FAIL clean_rd1: got %h last=%b to=%b expected be last=1 to=0", rd, rl, to);
      end
      finish_emit();
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL clean_done: done=%b err=%b busy=%b expected 1 0 0", done, err, busy);
      end
      checks++;
      if (chain_m !== 16'hC35A) begin errors++; $display("FAIL clean_chain: got %h expected c35a", chain_m); end
   endtask

   task automatic test_backpressure();
      logic [WW-1:0] rd, seq; logic rl; int lat, en_n; bit to, bad;
      do_start();
      xfer_word(8'h12, 1'b0, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || rd !== 8'h5A) begin
         errors++; $display("FAIL bp_rd0: got %h to=%b expected 5a to=0", rd, to);
      end
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_valid !== 1'b1 || m_data !== 8'h5A || s_ready !== 1'b0 || chain_en !== 1'b0) bad = 1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++; $display("FAIL bp_hold: m_valid=%b m_data=%h s_ready=%b chain_en=%b expected 1 5a 0 0",
                            m_valid, m_data, s_ready, chain_en);
      end
      finish_emit();
      xfer_word(8'h34, 1'b1, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || rd !== 8'hC3 || rl !== 1'b1) begin
         errors++; $display("FAIL bp_rd1: got %h last=%b expected c3 last=1", rd, rl);
      end
      finish_emit();
      checks++;
      if (done !== 1'b1 || chain_m !== 16'h3412) begin
         errors++; $display("FAIL bp_done: done=%b chain=%h expected 1 3412", done, chain_m);
      end
   endtask

   task automatic test_framing();
      logic [WW-1:0] rd, seq; logic rl; int lat, en_n; bit to, bad;
      do_start();
      s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL frame_early_last: err=%b busy=%b s_ready=%b done=%b expected 1 0 0 0",
                            err, busy, s_ready, done);
      end
      bad = 0;
      repeat (5) begin
         if (chain_en !== 1'b0) bad = 1;
         @(negedge clk);
      end
      checks++;
      if (bad !== 1'b0 || chain_m !== 16'h3412) begin
         errors++; $display("FAIL frame_no_shift: en_seen=%b chain=%h expected 0 3412", bad, chain_m);
      end
      do_start();
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL frame_restart: err=%b busy=%b expected 0 1", err, busy);
      end
      xfer_word(8'h99, 1'b0, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || rd !== 8'h12 || rl !== 1'b0) begin
         errors++; $display("FAIL frame_rd0: got %h last=%b expected 12 last=0", rd, rl);
      end
      finish_emit();
      s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL frame_missing_last: err=%b busy=%b done=%b expected 1 0 0", err, busy, done);
      end
      checks++;
      if (chain_m !== 16'h9934) begin errors++; $display("FAIL frame_chain: got %h expected 9934", chain_m); end
      do_start();
      xfer_word(8'hA1, 1'b0, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || rd !== 8'h34) begin errors++; $display("FAIL recover_rd0: got %h expected 34", rd); end
      finish_emit();
      xfer_word(8'hB2, 1'b1, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || rd !== 8'h99 || rl !== 1'b1) begin
         errors++; $display("FAIL recover_rd1: got %h last=%b expected 99 last=1", rd, rl);
      end
      finish_emit();
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || chain_m !== 16'hB2A1) begin
         errors++; $display("FAIL recover_done: done=%b err=%b chain=%h expected 1 0 b2a1", done, err, chain_m);
      end
   endtask

   task automatic test_start_during_shift();
      logic [WW-1:0] rd, seq; logic rl; int lat, en_n; bit to;
      do_start();
      xfer_word(8'h0F, 1'b0, 3, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || lat !== WW + 1 || en_n !== WW) begin
         errors++; $display("FAIL sds_burst: lat=%0d en=%0d to=%b expected %0d %0d 0", lat, en_n, to, WW + 1, WW);
      end
      checks++;
      if (rd !== 8'hA1 || rl !== 1'b0) begin
         errors++; $display("FAIL sds_rd0: got %h last=%b expected a1 last=0", rd, rl);
      end
      finish_emit();
      checks++;
      if (busy !== 1'b1 || s_ready !== 1'b1) begin
         errors++; $display("FAIL sds_next_load: busy=%b s_ready=%b expected 1 1", busy, s_ready);
      end
      xfer_word(8'hF0, 1'b1, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || rd !== 8'hB2 || rl !== 1'b1) begin
         errors++; $display("FAIL sds_rd1: got %h last=%b expected b2 last=1", rd, rl);
      end
      finish_emit();
      checks++;
      if (done !== 1'b1 || chain_m !== 16'hF00F) begin
         errors++; $display("FAIL sds_done: done=%b chain=%h expected 1 f00f", done, chain_m);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [WW-1:0] rd, seq; logic rl; int lat, en_n; bit to;
      do_start();
      s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (chain_en !== 1'b1) begin errors++; $display("FAIL rms_in_shift: chain_en=%b expected 1", chain_en); end
      reset = 1'b0;
      #1;
      checks++;
      if ({s_ready, m_valid, m_data, m_last, chain_di, chain_en, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL rms_outputs: got %b expected all zero",
                  {s_ready, m_valid, m_data, m_last, chain_di, chain_en, busy, done, err});
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0 || chain_m !== 16'h9E01) begin
         errors++; $display("FAIL rms_idle: busy=%b s_ready=%b chain=%h expected 0 0 9e01", busy, s_ready, chain_m);
      end
      do_start();
      xfer_word(8'h66, 1'b0, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || rd !== 8'h01) begin errors++; $display("FAIL rms_rd0: got %h expected 01", rd); end
      finish_emit();
      xfer_word(8'h99, 1'b1, 0, rd, rl, lat, en_n, seq, to);
      checks++;
      if (to !== 1'b0 || rd !== 8'h9E || rl !== 1'b1) begin
         errors++; $display("FAIL rms_rd1: got %h last=%b expected 9e last=1", rd, rl);
      end
      finish_emit();
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || chain_m !== 16'h9966) begin
         errors++; $display("FAIL rms_done: done=%b err=%b chain=%h expected 1 0 9966", done, err, chain_m);
      end
   endtask

   initial begin
      test_reset();
      test_clean_load();
      test_backpressure();
      test_framing();
      test_start_during_shift();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
